// File: rtl/if_fetch_if.sv
// Instruction SRAM-like bus between the fetch stage (master) and the inst memory (slave).
interface if_fetch_if;
  logic        req;
  logic [31:0] addr;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  modport master (output req, output addr, input addr_ok, input data_ok, input rdata);
  modport slave  (input req, input addr, output addr_ok, output data_ok, output rdata);
endinterface

// File: rtl/if_fetch.sv
// Instruction-fetch stage: PC, single-outstanding inst bus reads, delay-slot redirect, exception flush.
// Optional macro ADEL_CHECK_EN: misaligned PC raises if_adel instead of issuing a fetch.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'hBFC00000,
  parameter logic [31:0] NOP_INST = 32'h00000000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                stall_if,
  input  logic                redirect_valid,
  input  logic [31:0]         redirect_target,
  input  logic                exc_valid,
  input  logic [31:0]         exc_target,
  if_fetch_if.master          inst_sram,
  output logic                if_valid,
  output logic [31:0]         if_inst,
  output logic [31:0]         if_cur_instaddress,
  output logic [31:0]         if_next_instaddress,
  output logic                if_adel
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_DATA = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic        r_cancel;
  logic        r_pend_valid;
  logic [31:0] r_pend_target;
  logic [31:0] r_hold_buf;

  state_t      w_state_next;
  logic [31:0] w_pc_next;
  logic        w_cancel_next;
  logic        w_pend_valid_next;
  logic [31:0] w_pend_target_next;
  logic [31:0] w_hold_buf_next;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_npc;
  logic        w_misaligned;
  logic        w_req;
  logic        w_consume;
  logic        w_valid;
  logic [31:0] w_inst;
  logic        w_adel;

  assign w_pc_plus4 = r_pc + 32'd4;
  assign w_npc      = redirect_valid ? redirect_target :
                      (r_pend_valid ? r_pend_target : w_pc_plus4);

`ifdef ADEL_CHECK_EN
  assign w_misaligned   = (r_pc[1:0] != 2'b00);
  assign inst_sram.addr = r_pc;
`else
  assign w_misaligned   = 1'b0;
  assign inst_sram.addr = {r_pc[31:2], 2'b00};
`endif

  // The request line is gated by reset so nothing is issued while rst_n is low.
  assign inst_sram.req       = w_req & rst_n;
  assign if_valid            = w_valid;
  assign if_inst             = w_inst;
  assign if_adel             = w_adel;
  assign if_cur_instaddress  = r_pc;
  assign if_next_instaddress = w_pc_plus4;

  // Next-state, PC update and delivered-instruction logic.
  always_comb begin
    w_state_next       = r_state;
    w_pc_next          = r_pc;
    w_cancel_next      = r_cancel;
    w_pend_valid_next  = r_pend_valid;
    w_pend_target_next = r_pend_target;
    w_hold_buf_next    = r_hold_buf;
    w_req              = 1'b0;
    w_consume          = 1'b0;
    w_valid            = 1'b0;
    w_inst             = NOP_INST;
    w_adel             = 1'b0;

    case (r_state)
      S_REQ: begin
        if (w_misaligned) begin
          w_valid   = 1'b1;
          w_adel    = 1'b1;
          w_consume = !stall_if;
        end else begin
          w_req = 1'b1;
          if (inst_sram.addr_ok) begin
            w_state_next = S_DATA;
          end else begin
            w_state_next = S_REQ;
          end
        end
      end
      S_DATA: begin
        if (inst_sram.data_ok && r_cancel) begin
          w_cancel_next = 1'b0;
          w_state_next  = S_REQ;
        end else if (inst_sram.data_ok) begin
          w_valid = 1'b1;
          w_inst  = inst_sram.rdata;
          if (stall_if) begin
            w_hold_buf_next = inst_sram.rdata;
            w_state_next    = S_HOLD;
          end else begin
            w_consume    = 1'b1;
            w_state_next = S_REQ;
          end
        end else begin
          w_state_next = S_DATA;
        end
      end
      S_HOLD: begin
        w_valid = 1'b1;
        w_inst  = r_hold_buf;
        if (stall_if) begin
          w_state_next = S_HOLD;
        end else begin
          w_consume    = 1'b1;
          w_state_next = S_REQ;
        end
      end
      default: begin
        w_state_next = S_REQ;
      end
    endcase

    // A redirect arriving with the delay slot's consumption goes straight into the PC.
    if (w_consume) begin
      w_pc_next         = w_npc;
      w_pend_valid_next = 1'b0;
    end else if (redirect_valid) begin
      w_pend_target_next = redirect_target;
      w_pend_valid_next  = 1'b1;
    end else begin
      w_pend_valid_next = r_pend_valid;
    end

    // Exceptions override everything; an accepted or in-flight read is cancelled.
    if (exc_valid) begin
      w_pc_next         = exc_target;
      w_pend_valid_next = 1'b0;
      w_valid           = 1'b0;
      w_inst            = NOP_INST;
      w_adel            = 1'b0;
      case (r_state)
        S_REQ: begin
          if (w_req && inst_sram.addr_ok) begin
            w_state_next  = S_DATA;
            w_cancel_next = 1'b1;
          end else begin
            w_state_next = S_REQ;
          end
        end
        S_DATA: begin
          if (inst_sram.data_ok) begin
            w_state_next  = S_REQ;
            w_cancel_next = 1'b0;
          end else begin
            w_state_next  = S_DATA;
            w_cancel_next = 1'b1;
          end
        end
        default: begin
          w_state_next = S_REQ;
        end
      endcase
    end else begin
      w_pc_next = w_pc_next;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_REQ;
      r_pc          <= RESET_PC;
      r_cancel      <= 1'b0;
      r_pend_valid  <= 1'b0;
      r_pend_target <= 32'h00000000;
      r_hold_buf    <= 32'h00000000;
    end else begin
      r_state       <= w_state_next;
      r_pc          <= w_pc_next;
      r_cancel      <= w_cancel_next;
      r_pend_valid  <= w_pend_valid_next;
      r_pend_target <= w_pend_target_next;
      r_hold_buf    <= w_hold_buf_next;
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: inputs change after negedge, outputs checked 1 ns later.
module tb_if_fetch;
  logic        clk;
  logic        rst_n;
  logic        stall_if;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        exc_valid;
  logic [31:0] exc_target;
  logic        if_valid;
  logic [31:0] if_inst;
  logic [31:0] if_cur_instaddress;
  logic [31:0] if_next_instaddress;
  logic        if_adel;
  int          n_total;
  int          n_pass;

  if_fetch_if u_bus ();

  if_fetch u_dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .stall_if            (stall_if),
    .redirect_valid      (redirect_valid),
    .redirect_target     (redirect_target),
    .exc_valid           (exc_valid),
    .exc_target          (exc_target),
    .inst_sram           (u_bus),
    .if_valid            (if_valid),
    .if_inst             (if_inst),
    .if_cur_instaddress  (if_cur_instaddress),
    .if_next_instaddress (if_next_instaddress),
    .if_adel             (if_adel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Advance to the next negedge and clear all pulse inputs.
  task automatic next_cycle();
    @(negedge clk);
    u_bus.addr_ok   = 1'b0;
    u_bus.data_ok   = 1'b0;
    redirect_valid  = 1'b0;
    exc_valid       = 1'b0;
  endtask

  initial begin
    n_total         = 0;
    n_pass          = 0;
    rst_n           = 1'b0;
    stall_if        = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = 32'h00000000;
    exc_valid       = 1'b0;
    exc_target      = 32'h00000000;
    u_bus.addr_ok   = 1'b0;
    u_bus.data_ok   = 1'b0;
    u_bus.rdata     = 32'h00000000;

    // Reset state
    @(negedge clk);
    #1;
    chk1 ("rst_req",   u_bus.req, 1'b0);
    chk1 ("rst_valid", if_valid, 1'b0);
    chk32("rst_inst",  if_inst, 32'h00000000);
    chk1 ("rst_adel",  if_adel, 1'b0);
    chk32("rst_cur",   if_cur_instaddress, 32'hBFC00000);
    chk32("rst_next",  if_next_instaddress, 32'hBFC00004);

    // Sequential fetch, addr_ok/data_ok one cycle each
    next_cycle(); rst_n = 1'b1; u_bus.addr_ok = 1'b1; #1;
    chk1 ("c0_req", u_bus.req, 1'b1);
    chk32("c0_addr", u_bus.addr, 32'hBFC00000);
    chk1 ("c0_valid", if_valid, 1'b0);
    next_cycle(); u_bus.data_ok = 1'b1; u_bus.rdata = 32'h11111111; #1;
    chk1 ("c1_req", u_bus.req, 1'b0);
    chk1 ("c1_valid", if_valid, 1'b1);
    chk32("c1_inst", if_inst, 32'h11111111);
    next_cycle(); u_bus.addr_ok = 1'b1; #1;
    chk32("c2_addr", u_bus.addr, 32'hBFC00004);
    chk1 ("c2_valid", if_valid, 1'b0);
    next_cycle(); u_bus.data_ok = 1'b1; u_bus.rdata = 32'h22222222; #1;
    chk32("c3_inst", if_inst, 32'h22222222);
    next_cycle(); u_bus.addr_ok = 1'b1; #1;
    chk32("c4_addr", u_bus.addr, 32'hBFC00008);

    // Stall for three cycles on data return
    next_cycle(); u_bus.data_ok = 1'b1; u_bus.rdata = 32'h24020005; stall_if = 1'b1; #1;
    chk32("c5_inst", if_inst, 32'h24020005);
    next_cycle(); u_bus.rdata = 32'hDEADBEEF; #1;
    chk1 ("c6_valid", if_valid, 1'b1);
    chk32("c6_inst", if_inst, 32'h24020005);
    chk1 ("c6_req", u_bus.req, 1'b0);
    chk32("c6_cur", if_cur_instaddress, 32'hBFC00008);
    next_cycle(); #1;
    chk32("c7_inst", if_inst, 32'h24020005);
    next_cycle(); stall_if = 1'b0; #1;
    chk32("c8_inst", if_inst, 32'h24020005);
    next_cycle(); u_bus.addr_ok = 1'b1; #1;
    chk32("c9_addr", u_bus.addr, 32'hBFC0000C);

    // Deferred redirect: delay slot at BFC0000C still delivered
    next_cycle(); redirect_valid = 1'b1; redirect_target = 32'hBFC00100; #1;
    chk1 ("c10_valid", if_valid, 1'b0);
    next_cycle(); u_bus.data_ok = 1'b1; u_bus.rdata = 32'h33333333; #1;
    chk32("c11_inst", if_inst, 32'h33333333);
    chk32("c11_cur", if_cur_instaddress, 32'hBFC0000C);
    next_cycle(); u_bus.addr_ok = 1'b1; #1;
    chk32("c12_addr", u_bus.addr, 32'hBFC00100);
    chk32("c12_next", if_next_instaddress, 32'hBFC00104);

    // Redirect in the consume cycle takes effect directly
    next_cycle(); u_bus.data_ok = 1'b1; u_bus.rdata = 32'h44444444;
    redirect_valid = 1'b1; redirect_target = 32'hBFC00200; #1;
    chk32("c13_inst", if_inst, 32'h44444444);
    next_cycle(); u_bus.addr_ok = 1'b1; #1;
    chk32("c14_addr", u_bus.addr, 32'hBFC00200);

    // Exception while waiting for data; late data is dropped
    next_cycle(); exc_valid = 1'b1; exc_target = 32'hBFC00380; #1;
    chk1 ("c15_valid", if_valid, 1'b0);
    next_cycle(); #1;
    chk32("c16_cur", if_cur_instaddress, 32'hBFC00380);
    chk1 ("c16_req", u_bus.req, 1'b0);
    next_cycle(); u_bus.data_ok = 1'b1; u_bus.rdata = 32'h55555555; #1;
    chk1 ("c17_valid", if_valid, 1'b0);
    chk32("c17_inst", if_inst, 32'h00000000);
    next_cycle(); u_bus.addr_ok = 1'b1; #1;
    chk32("c18_addr", u_bus.addr, 32'hBFC00380);
    next_cycle(); u_bus.data_ok = 1'b1; u_bus.rdata = 32'h66666666; #1;
    chk32("c19_inst", if_inst, 32'h66666666);

    // Exception and redirect in the same cycle: redirect lost
    next_cycle(); exc_valid = 1'b1; exc_target = 32'hBFC00380;
    redirect_valid = 1'b1; redirect_target = 32'h12345678; #1;
    chk1 ("c20_valid", if_valid, 1'b0);
    chk32("c20_addr", u_bus.addr, 32'hBFC00384);
    next_cycle(); u_bus.addr_ok = 1'b1; #1;
    chk32("c21_addr", u_bus.addr, 32'hBFC00380);
    next_cycle(); u_bus.data_ok = 1'b1; u_bus.rdata = 32'h77777777; #1;
    chk1 ("c22_valid", if_valid, 1'b1);
    next_cycle(); #1;
    chk1 ("c23_req", u_bus.req, 1'b1);
    chk32("c23_addr", u_bus.addr, 32'hBFC00384);
    next_cycle(); u_bus.addr_ok = 1'b1; #1;
    chk32("c24_addr", u_bus.addr, 32'hBFC00384);

    // Exception while holding a stalled instruction, then PC wrap
    next_cycle(); u_bus.data_ok = 1'b1; u_bus.rdata = 32'h88888888; stall_if = 1'b1; #1;
    chk32("c25_inst", if_inst, 32'h88888888);
    next_cycle(); exc_valid = 1'b1; exc_target = 32'hFFFFFFFC; #1;
    chk1 ("c26_valid", if_valid, 1'b0);
    next_cycle(); stall_if = 1'b0; u_bus.addr_ok = 1'b1; #1;
    chk32("c27_addr", u_bus.addr, 32'hFFFFFFFC);
    chk32("c27_next", if_next_instaddress, 32'h00000000);
    next_cycle(); u_bus.data_ok = 1'b1; u_bus.rdata = 32'h99999999; #1;
    chk32("c28_inst", if_inst, 32'h99999999);
    next_cycle(); #1;
    chk32("c29_cur", if_cur_instaddress, 32'h00000000);
    chk32("c29_addr", u_bus.addr, 32'h00000000);

    // Misaligned exception target
    next_cycle(); exc_valid = 1'b1; exc_target = 32'hBFC00381; #1;
    chk1 ("c30_valid", if_valid, 1'b0);
    next_cycle(); #1;
    chk32("c31_cur", if_cur_instaddress, 32'hBFC00381);
`ifdef ADEL_CHECK_EN
    chk1 ("c31_req", u_bus.req, 1'b0);
    chk1 ("c31_adel", if_adel, 1'b1);
    chk1 ("c31_valid", if_valid, 1'b1);
    chk32("c31_inst", if_inst, 32'h00000000);
`else
    chk1 ("c31_req", u_bus.req, 1'b1);
    chk1 ("c31_adel", if_adel, 1'b0);
    chk32("c31_addr", u_bus.addr, 32'hBFC00380);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
